decode_seq_ctrl: RTL and testbench

//   Multi-cycle control sequencer that drives the instruction decoder of the RV32I core.

---
 rtl/decode_seq_ctrl.sv | 174 +++++++++++++++++
 tb/tb_decode_seq_ctrl.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/decode_seq_ctrl.sv
// Multi-cycle control sequencer for the RV32I decoder: fetch, decode, execute,
// data access and writeback, with sticky traps on illegal encodings and bus timeouts.
module decode_seq_ctrl #(
    parameter int unsigned TIMEOUT  = 16,
    parameter int unsigned CNT_W    = 32,
    parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    output logic             o_imem_req,
    input  logic             i_imem_ack,
    input  logic [31:0]      i_imem_rdata,
    output logic [31:0]      o_inst,
    input  logic             i_illegal,
    input  logic             i_is_load,
    input  logic             i_is_store,
    input  logic             i_is_branch,
    input  logic             i_stall,
    output logic             o_dmem_req,
    input  logic             i_dmem_ack,
    output logic             o_rf_we,
    output logic             o_pc_we,
    output logic             o_trap,
    output logic [1:0]       o_trap_cause,
    input  logic             i_trap_clr,
    output logic [CNT_W-1:0] o_cycle,
    output logic [CNT_W-1:0] o_instret,
    output logic [2:0]       o_state
);

    // Bus handshake: a request stays high from the first cycle of FETCH/MEM until
    // the cycle in which the matching ack is seen; ack is sampled only while req is high.

    localparam int unsigned TMO_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);

    localparam logic [1:0] CAUSE_NONE  = 2'd0;
    localparam logic [1:0] CAUSE_FETCH = 2'd1;
    localparam logic [1:0] CAUSE_ILL   = 2'd2;
    localparam logic [1:0] CAUSE_DATA  = 2'd3;

    typedef enum logic [2:0] {
        S_FETCH     = 3'd0,
        S_DECODE    = 3'd1,
        S_EXECUTE   = 3'd2,
        S_MEM       = 3'd3,
        S_WRITEBACK = 3'd4,
        S_TRAP      = 3'd5
    } state_t;

    state_t            state_q, state_d;
    logic [TMO_W-1:0]  tmo_q;
    logic              tmo_expire;
    logic [31:0]       inst_q;
    logic [1:0]        cause_q, cause_d;
    logic              is_load_q, no_rd_q;
    logic              imem_req;
    logic [CNT_W-1:0]  cycle_q, instret_q;

    assign tmo_expire = (tmo_q == TMO_LAST);

    always_comb begin
        state_d    = state_q;
        cause_d    = CAUSE_NONE;
        imem_req   = 1'b0;
        o_dmem_req = 1'b0;
        o_rf_we    = 1'b0;
        o_pc_we    = 1'b0;
        case (state_q)
            S_FETCH: begin
                imem_req = 1'b1;
                if (i_imem_ack) begin
                    state_d = S_DECODE;
                end else if (tmo_expire) begin
                    state_d = S_TRAP;
                    cause_d = CAUSE_FETCH;
                end
            end
            S_DECODE: begin
                if (!i_stall) begin
                    if (i_illegal) begin
                        state_d = S_TRAP;
                        cause_d = CAUSE_ILL;
                    end else begin
                        state_d = S_EXECUTE;
                    end
                end
            end
            S_EXECUTE: begin
                if (!i_stall) begin
                    state_d = (i_is_load || i_is_store) ? S_MEM : S_WRITEBACK;
                end
            end
            S_MEM: begin
                o_dmem_req = 1'b1;
                if (i_dmem_ack) begin
                    if (is_load_q) begin
                        state_d = S_WRITEBACK;
                    end else begin
                        // stores retire straight out of the data access
                        o_pc_we = 1'b1;
                        state_d = S_FETCH;
                    end
                end else if (tmo_expire) begin
                    state_d = S_TRAP;
                    cause_d = CAUSE_DATA;
                end
            end
            S_WRITEBACK: begin
                if (!i_stall) begin
                    o_pc_we = 1'b1;
                    o_rf_we = !no_rd_q;
                    state_d = S_FETCH;
                end
            end
            S_TRAP: begin
                if (i_trap_clr) begin
                    state_d = S_FETCH;
                end
            end
            default: state_d = S_FETCH;
        endcase
    end

    // Gating with reset keeps the fetch request low while reset is held.
    assign o_imem_req = imem_req & i_rst_n;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q   <= S_FETCH;
            tmo_q     <= '0;
            inst_q    <= NOP_INST;
            cause_q   <= CAUSE_NONE;
            is_load_q <= 1'b0;
            no_rd_q   <= 1'b0;
            cycle_q   <= '0;
            instret_q <= '0;
        end else begin
            state_q <= state_d;
            cycle_q <= cycle_q + CNT_W'(1);
            if (o_pc_we) begin
                instret_q <= instret_q + CNT_W'(1);
            end
            if (state_d != state_q) begin
                tmo_q <= '0;
            end else if (state_q == S_FETCH || state_q == S_MEM) begin
                tmo_q <= tmo_q + TMO_W'(1);
            end
            if (state_q == S_FETCH && i_imem_ack) begin
                inst_q <= i_imem_rdata;
            end else if (state_q == S_TRAP && i_trap_clr) begin
                inst_q <= NOP_INST;
            end
            if (state_d == S_TRAP && state_q != S_TRAP) begin
                cause_q <= cause_d;
            end else if (state_q == S_TRAP && i_trap_clr) begin
                cause_q <= CAUSE_NONE;
            end
            // class flags are captured while o_inst is stable in EXECUTE
            if (state_q == S_EXECUTE) begin
                is_load_q <= i_is_load;
                no_rd_q   <= i_is_store || i_is_branch;
            end
        end
    end

    assign o_inst       = inst_q;
    assign o_trap       = (state_q == S_TRAP);
    assign o_trap_cause = cause_q;
    assign o_cycle      = cycle_q;
    assign o_instret    = instret_q;
    assign o_state      = state_q;

endmodule

// File: tb/tb_decode_seq_ctrl.sv
// Randomized bench for decode_seq_ctrl: each instruction is described by its wait and
// stall lengths, and the expected per-cycle strobes come from a timeline computed from those.
module tb_decode_seq_ctrl;

    localparam int TIMEOUT = 16;
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        imem_req, imem_ack, illegal, is_load, is_store, is_branch, stall;
    logic [31:0] imem_rdata, inst;
    logic        dmem_req, dmem_ack, rf_we, pc_we, trap, trap_clr;
    logic [1:0]  trap_cause;
    logic [31:0] cycle, instret;
    logic [2:0]  state;

    decode_seq_ctrl #(.TIMEOUT(TIMEOUT), .CNT_W(32), .NOP_INST(NOP)) dut (
        .i_clk(clk), .i_rst_n(rst_n),
        .o_imem_req(imem_req), .i_imem_ack(imem_ack), .i_imem_rdata(imem_rdata),
        .o_inst(inst), .i_illegal(illegal), .i_is_load(is_load), .i_is_store(is_store),
        .i_is_branch(is_branch), .i_stall(stall), .o_dmem_req(dmem_req), .i_dmem_ack(dmem_ack),
        .o_rf_we(rf_we), .o_pc_we(pc_we), .o_trap(trap), .o_trap_cause(trap_cause),
        .i_trap_clr(trap_clr), .o_cycle(cycle), .o_instret(instret), .o_state(state)
    );

    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_fail = 0;
    int          cyc = 0;
    logic [31:0] exp_inst = NOP;
    logic [31:0] exp_instret = 0;
    logic [31:0] exp_q[$];

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        cyc++;
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        imem_ack = 0; imem_rdata = 0; dmem_ack = 0; illegal = 0;
        is_load = 0; is_store = 0; is_branch = 0; stall = 0; trap_clr = 0;
    endtask

    task automatic random_flags();
        illegal   = ($urandom_range(0, 1) != 0);
        is_load   = ($urandom_range(0, 1) != 0);
        is_store  = ($urandom_range(0, 1) != 0);
        is_branch = ($urandom_range(0, 1) != 0);
    endtask

    task automatic check_reset_values();
        check("rst_imem_req", imem_req, 0);
        check("rst_dmem_req", dmem_req, 0);
        check("rst_rf_we", rf_we, 0);
        check("rst_pc_we", pc_we, 0);
        check("rst_trap", trap, 0);
        check("rst_cause", trap_cause, 0);
        check("rst_inst", inst, NOP);
        check("rst_cycle", cycle, 0);
        check("rst_instret", instret, 0);
    endtask

    task automatic apply_reset();
        rst_n = 0;
        idle_inputs();
        #1;
        check_reset_values();
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_reset_values();
        rst_n = 1;
        cyc = 0;
        exp_inst = NOP;
        exp_instret = 0;
        exp_q.delete();
    endtask

    task automatic handle_trap(input int cause);
        int hold;
        hold = $urandom_range(0, 3);
        for (int h = 0; h <= hold; h++) begin
            imem_ack = 0; dmem_ack = 0;
            imem_rdata = $urandom;
            stall = ($urandom_range(0, 1) != 0);
            random_flags();
            trap_clr = (h == hold);
            #1;
            check("trap_on", trap, 1);
            check("trap_cause", trap_cause, cause);
            check("trap_imem_req", imem_req, 0);
            check("trap_dmem_req", dmem_req, 0);
            check("trap_strobes", {rf_we, pc_we}, 0);
            check("trap_inst", inst, exp_inst);
            tick();
        end
        trap_clr = 0;
        exp_inst = NOP;
        #1;
        check("clr_trap", trap, 0);
        check("clr_cause", trap_cause, 0);
        check("clr_inst", inst, NOP);
        check("clr_imem_req", imem_req, 1);
        check("clr_instret", instret, exp_instret);
    endtask

    // cls: 0 alu, 1 load, 2 store, 3 branch. f/m: cycles of waiting before imem/dmem ack
    // (>= TIMEOUT means no ack). d/s/w: stall cycles in decode/execute/writeback.
    task automatic run_instr(input logic [31:0] word, input int cls, input bit ill,
                             input int f, input int d, input int s, input int m,
                             input int w, input int abort_k);
        int kind, e0, m0, wb0, mem_end, last_k;
        bit is_mem, writes_rd, in_dec, in_exe, in_mem, in_wb, retire;
        logic [31:0] cur_inst, head;
        is_mem = (cls == 1) || (cls == 2);
        writes_rd = (cls == 0) || (cls == 1);
        e0 = f + 2 + d;
        m0 = e0 + s + 1;
        if (f >= TIMEOUT) begin
            kind = 1; last_k = TIMEOUT - 1;
        end else if (ill) begin
            kind = 2; last_k = f + 1 + d;
        end else if (is_mem && m >= TIMEOUT) begin
            kind = 3; last_k = m0 + TIMEOUT - 1;
        end else begin
            kind = 0;
            if (cls == 2) last_k = m0 + m;
            else if (is_mem) last_k = m0 + m + 1 + w;
            else last_k = e0 + s + 1 + w;
        end
        mem_end = (kind == 3) ? last_k : m0 + m;
        wb0 = is_mem ? m0 + m + 1 : e0 + s + 1;
        cur_inst = exp_inst;
        for (int k = 0; k <= last_k; k++) begin
            in_dec = (kind != 1) && k >= f + 1 && k <= f + 1 + d;
            in_exe = (kind == 0 || kind == 3) && k >= e0 && k <= e0 + s;
            in_mem = is_mem && (kind == 0 || kind == 3) && k >= m0 && k <= mem_end;
            in_wb  = (kind == 0) && (cls != 2) && k >= wb0 && k <= last_k;
            retire = (kind == 0) && (k == last_k);
            imem_ack = (kind != 1) && (k == f);
            imem_rdata = imem_ack ? word : $urandom;
            dmem_ack = in_mem && (kind == 0) && (k == mem_end);
            if (in_dec) stall = (k < f + 1 + d);
            else if (in_exe) stall = (k < e0 + s);
            else if (in_wb) stall = (k < last_k);
            else stall = ($urandom_range(0, 1) != 0);
            if (in_dec || in_exe) begin
                illegal = ill; is_load = (cls == 1); is_store = (cls == 2); is_branch = (cls == 3);
            end else begin
                random_flags();
            end
            trap_clr = ($urandom_range(0, 1) != 0);
            if (kind != 1 && k == f + 1) cur_inst = word;
            #1;
            check("imem_req", imem_req, (kind == 1) || (k <= f));
            check("dmem_req", dmem_req, in_mem);
            check("rf_we", rf_we, retire && writes_rd);
            check("pc_we", pc_we, retire);
            check("trap_off", trap, 0);
            check("inst", inst, cur_inst);
            if (kind != 1 && k == f) exp_q.push_back(word);
            if (kind != 1 && k == last_k && exp_q.size() > 0) begin
                head = exp_q.pop_front();
                check("retire_inst", inst, head);
            end
            if (k == abort_k) begin
                apply_reset();
                return;
            end
            tick();
        end
        if (kind == 0) exp_instret++;
        if (kind != 1) exp_inst = word;
        check("instret", instret, exp_instret);
        check("cycle", cycle, cyc);
        if (kind != 0) handle_trap(kind);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed no finish expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] word;
        int cls, f, m;
        bit ill;
        rst_n = 1;
        idle_inputs();
        #2;
        apply_reset();
        run_instr(32'h0010_0093, 0, 0, 1, 0, 0, 0, 0, -1);
        run_instr(32'h0000_a103, 1, 0, 0, 0, 0, 3, 0, -1);
        run_instr(32'h0020_a023, 2, 0, 0, 0, 0, 2, 0, -1);
        run_instr(32'h0020_8463, 3, 0, 2, 0, 0, 0, 0, -1);
        run_instr(32'h0010_0093, 0, 0, TIMEOUT, 0, 0, 0, 0, -1);
        run_instr(32'h0000_0000, 0, 1, 0, 0, 0, 0, 0, -1);
        run_instr(32'h0050_0113, 0, 0, 0, 0, 5, 0, 0, -1);
        run_instr(32'h0030_0193, 0, 0, TIMEOUT - 1, 2, 0, 0, 3, -1);
        run_instr(32'h0040_a203, 1, 0, 0, 0, 0, TIMEOUT, 0, -1);
        run_instr(32'h0040_a223, 2, 0, 0, 1, 1, TIMEOUT - 1, 0, -1);
        run_instr(32'h0000_0000, 3, 1, 3, 3, 0, 0, 0, -1);
        for (int i = 0; i < 60; i++) begin
            word = $urandom;
            cls = $urandom_range(0, 3);
            ill = ($urandom_range(0, 7) == 0);
            f = ($urandom_range(0, 9) == 0) ? TIMEOUT : $urandom_range(0, 4);
            m = ($urandom_range(0, 9) == 0) ? TIMEOUT : $urandom_range(0, 5);
            run_instr(word, cls, ill, f, $urandom_range(0, 2), $urandom_range(0, 2), m,
                      $urandom_range(0, 2), -1);
        end
        run_instr(32'h0000_a283, 1, 0, 0, 0, 0, 10, 0, 6);
        run_instr(32'h0010_0093, 0, 0, 0, 0, 0, 0, 0, -1);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
